// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the byte-serial instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int INST_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_INST = 4;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } q_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Instruction queue: synchronous FIFO with flush; head output holds its last
// value while the queue is empty.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  q_entry_t push_data_i,
  input  logic     pop_i,
  input  logic     flush_i,
  output logic [CW-1:0] count_o,
  output q_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);

  q_entry_t          mem_q [DEPTH];
  q_entry_t          last_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign count_o = count_q;
  // Showing last_q when empty keeps inst/inst_pc at the last value seen downstream.
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= head_o;
    end else begin
      last_q <= head_o;
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial fetch: assembles big-endian 32-bit words from a byte-wide imem
// and queues them for decode behind a valid/ready handshake.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          IMEM_AW    = 5,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [BYTE_W-1:0]   imem_data,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst,
  output logic [31:0]         inst_pc,
  output logic [CW-1:0]       q_count
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [INST_W-1:0]  asm_q, asm_d;
  logic               push, pop;
  logic [CW-1:0]      count_after;
  q_entry_t           push_entry, head;

  assign imem_addr  = fetch_pc_q[IMEM_AW-1:0] + IMEM_AW'(byte_cnt_q);
  assign inst_valid = (q_count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = (state_q == ST_FETCH) && (byte_cnt_q == 2'd3);
  assign push_entry = '{inst: asm_d, pc: fetch_pc_q};
  assign count_after = q_count + CW'(push) - CW'(pop);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  always_comb begin
    asm_d = asm_q;
    // Byte 0 lands in the most significant lane (big-endian).
    for (int i = 0; i < BYTES_PER_INST; i++) begin
      if (byte_cnt_q == 2'(i))
        asm_d[(BYTES_PER_INST-1-i)*BYTE_W +: BYTE_W] = imem_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    if (redirect_valid) begin
      state_d    = ST_FETCH;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (count_after == CW'(FIFO_DEPTH)) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (q_count < CW'(FIFO_DEPTH)) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= redirect_valid ? '0 : (state_q == ST_FETCH ? asm_d : asm_q);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (q_count),
    .head_o      (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 32-byte behavioural imem.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  imem_addr;
  logic [7:0]  imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  q_count;

  logic [7:0]  imem [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  instr_fetch_unit #(.IMEM_AW(5), .FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .q_count        (q_count)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    step(2);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", inst_pc); end
    checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", q_count); end
    checks++; if (imem_addr !== 5'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_free_run();
    rst = 1'b0; inst_ready = 1'b1;
    step(3);
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 5'd3) begin errors++;
      $display("FAIL fr_latency valid %0b addr %h exp 0/03", inst_valid, imem_addr); end
    step(1);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h8C040000 || inst_pc !== 32'h0) begin errors++;
      $display("FAIL fr_word0 valid %0b inst %h pc %h exp 1/8C040000/0", inst_valid, inst, inst_pc); end
    step(1);
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h8C040000) begin errors++;
      $display("FAIL fr_hold_empty valid %0b inst %h exp 0/8C040000", inst_valid, inst); end
    step(3);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'hAC050004 || inst_pc !== 32'h4 || q_count !== 2'd1) begin errors++;
      $display("FAIL fr_word1 inst %h pc %h cnt %0d exp AC050004/4/1", inst, inst_pc, q_count); end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    do_reset();
    step(8);
    checks++; if (q_count !== 2'd2 || imem_addr !== 5'h08 || inst_pc !== 32'h0) begin errors++;
      $display("FAIL bp_full cnt %0d addr %h pc %h exp 2/08/0", q_count, imem_addr, inst_pc); end
    step(2);
    checks++; if (q_count !== 2'd2 || imem_addr !== 5'h08 || inst !== 32'h8C040000) begin errors++;
      $display("FAIL bp_hold cnt %0d addr %h inst %h exp 2/08/8C040000", q_count, imem_addr, inst); end
    inst_ready = 1'b1;
    step(1);
    checks++; if (q_count !== 2'd1 || inst_pc !== 32'h4 || inst !== 32'hAC050004) begin errors++;
      $display("FAIL bp_pop0 cnt %0d pc %h inst %h exp 1/4/AC050004", q_count, inst_pc, inst); end
    step(1);
    checks++; if (q_count !== 2'd0 || imem_addr !== 5'h08) begin errors++;
      $display("FAIL bp_pop1 cnt %0d addr %h exp 0/08", q_count, imem_addr); end
    step(1);
    checks++; if (imem_addr !== 5'h09) begin errors++;
      $display("FAIL bp_resume addr %h exp 09", imem_addr); end
  endtask

  task automatic test_redirect();
    inst_ready = 1'b0;
    do_reset();
    step(8);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    step(1);
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || q_count !== 2'd0 || imem_addr !== 5'h10) begin errors++;
      $display("FAIL rd_flush valid %0b cnt %0d addr %h exp 0/0/10", inst_valid, q_count, imem_addr); end
    step(3);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_early valid %0b exp 0", inst_valid); end
    step(1);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== 32'h20212223) begin errors++;
      $display("FAIL rd_first pc %h inst %h exp 10/20212223", inst_pc, inst); end
  endtask

  task automatic test_wrap();
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_001C;
    step(1);
    redirect_valid = 1'b0;
    step(4);
    checks++; if (inst_pc !== 32'h1C || inst !== 32'h2C2D2E2F || imem_addr !== 5'h00) begin errors++;
      $display("FAIL wr_last pc %h inst %h addr %h exp 1C/2C2D2E2F/00", inst_pc, inst, imem_addr); end
    step(4);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'h8C040000) begin errors++;
      $display("FAIL wr_next pc %h inst %h exp 20/8C040000", inst_pc, inst); end
  endtask

  task automatic test_redirect_on_push();
    inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    step(7);
    checks++; if (q_count !== 2'd1 || imem_addr !== 5'h07) begin errors++;
      $display("FAIL rp_setup cnt %0d addr %h exp 1/07", q_count, imem_addr); end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
    step(1);
    redirect_valid = 1'b0;
    checks++; if (q_count !== 2'd0 || inst_valid !== 1'b0 || imem_addr !== 5'h08) begin errors++;
      $display("FAIL rp_discard cnt %0d valid %0b addr %h exp 0/0/08", q_count, inst_valid, imem_addr); end
    step(4);
    checks++; if (q_count !== 2'd1 || inst_pc !== 32'h8 || inst !== 32'h18191A1B) begin errors++;
      $display("FAIL rp_refetch cnt %0d pc %h inst %h exp 1/8/18191A1B", q_count, inst_pc, inst); end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    step(2);
    checks++; if (imem_addr !== 5'h0E) begin errors++; $display("FAIL rm_setup addr %h exp 0E", imem_addr); end
    rst = 1'b1;
    step(1);
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || q_count !== 2'd0 || imem_addr !== 5'h0) begin errors++;
      $display("FAIL rm_clear valid %0b inst %h pc %h cnt %0d addr %h exp all 0", inst_valid, inst, inst_pc, q_count, imem_addr); end
    rst = 1'b0;
    step(4);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h8C040000 || inst_pc !== 32'h0) begin errors++;
      $display("FAIL rm_refetch inst %h pc %h exp 8C040000/0", inst, inst_pc); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 8'h10 + 8'(i);
    imem[0] = 8'h8C; imem[1] = 8'h04; imem[2] = 8'h00; imem[3] = 8'h00;
    imem[4] = 8'hAC; imem[5] = 8'h05; imem[6] = 8'h00; imem[7] = 8'h04;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_on_push();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
